axi_chan_buffer: RTL
====================

# axi_chan_buffer

Parametrised ready/valid buffer for a single AXI channel (AW, W, AR, R or B), the successor to the fixed single-slice register. Depth is arbitrary, including non-power-of-two. The block adds a synchronous flush, a fill-level output and an almost-full flag. It sits between an AXI master port and an interconnect or crossbar port, one instance per channel. `ready_o` and `valid_o` are driven from registered state only, so each instance breaks every combinational handshake path.

## Interface
- `DATA_WIDTH`, default 64: payload width in bits (packed AXI channel struct), must be ≥ 1.
- `DEPTH`, default 2: number of storage entries, must be ≥ 1, any integer.
- `ALMOST_FULL_TH`, default `DEPTH-1`: fill level at which `almost_full_o` asserts, range 1..`DEPTH`.
- `CNT_W` (localparam): `$clog2(DEPTH+1)`.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `testmode_i`  in  1  test mode; no functional effect, carried for DFT uniformity.
- `flush_i`  in  1  synchronous flush; discards all stored entries.
- `valid_i`  in  1  upstream valid.
- `ready_o`  out  1  upstream ready.
- `data_i`  in  `DATA_WIDTH`  upstream payload.
- `valid_o`  out  1  downstream valid.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  `DATA_WIDTH`  downstream payload.
- `usage_o`  out  `CNT_W`  current fill level, 0..`DEPTH`.
- `almost_full_o`  out  1  high when `usage_o` ≥ `ALMOST_FULL_TH`.

## Operation
- **Storage:** circular buffer `mem[DEPTH]` with write pointer `wr_ptr`, read pointer `rd_ptr` and counter `count`.
- **Handshakes:**
  - push = `valid_i & ready_o`.
  - pop = `valid_o & ready_i`.
- **Outputs:**
  - `ready_o` = (`count` != `DEPTH`).
  - `valid_o` = (`count` != 0).
  - `data_o` = `mem[rd_ptr]`.
  - `usage_o` = `count`.
- **Push:** `mem[wr_ptr]` ← `data_i`; `wr_ptr` increments.
- **Pop:** `rd_ptr` increments.
- **Pointer wrap:** a pointer at `DEPTH-1` wraps to 0. It is an explicit compare, not a power-of-two truncation.
- **Count update:** push only → +1; pop only → −1; push and pop together → unchanged, with both pointers advancing.
- **Full:** `ready_o`=0. Push and pop cannot occur in the same cycle, because there is no `ready_i`→`ready_o` path. The pop frees a slot visible on the next cycle.
- **Empty:** `valid_o`=0 and `data_o` holds the stale entry; downstream must ignore it.
- **Flush:**
  - Next cycle: `count`, `wr_ptr` and `rd_ptr` are 0.
  - Any push or pop handshake completing in the flush cycle is dropped and has no effect.
  - `mem` contents are kept.
- **Stability:** `valid_i`/`data_i` are not required to stay stable by this block. `valid_o`/`data_o` stay stable while `valid_o & ~ready_i` (AXI rule), except across a flush.

## Timing
- **Reset values:**
  - `count`, `wr_ptr`, `rd_ptr` = 0.
  - `mem` = all zero.
  - Outputs: `ready_o`=1, `valid_o`=0, `data_o`=0, `usage_o`=0, `almost_full_o`=0.
- **Reset mid-operation:** all in-flight entries are lost. Outputs take their reset values asynchronously on `rst_ni` falling.
- **Latency:** push at edge N → `valid_o`=1 from cycle N+1 (1 cycle). The fall-through exception is described under Configuration.
- **Throughput:**
  - `DEPTH` ≥ 2: 1 beat/cycle sustained.
  - `DEPTH` = 1: 1 beat per 2 cycles.
- **Critical paths:** none combinational from input to output except `data_o` mux; all handshake outputs decode from registers.

## Configuration
- **Macro:** `AXI_CHAN_BUFFER_FALL_THROUGH_EN`.
- **Defined:**
  - When `count`==0 and `valid_i`=1, `valid_o`=1 and `data_o`=`data_i` in the same cycle.
  - If `ready_i`=1 in that cycle, the beat bypasses storage: no pointer or count change.
  - If `ready_i`=0, the beat is pushed normally.
  - Latency is 0 cycles when empty. This adds a combinational `valid_i`→`valid_o` and `data_i`→`data_o` path.
  - Flush still drops a bypassed beat.
- **Undefined:** the behaviour described above (latency 1 cycle, registered outputs).

## Test plan
- **Reset values:** assert `rst_ni`=0 mid-burst with `count`=2 → immediately `ready_o`=1, `valid_o`=0, `usage_o`=0, `data_o`=0.
- **Fill to full, non-power-of-two:** `DEPTH`=3, `ready_i`=0, push 0xA,0xB,0xC,0xD.
  - `usage_o` = 1,2,3.
  - `ready_o`=0 after the third push; 0xD is held off.
  - Drain yields 0xA,0xB,0xC in order.
- **Streaming and wrap:** `DEPTH`=3, `valid_i`=`ready_i`=1 for 10 cycles with incrementing data → every beat delivered in order, `usage_o` constant, pointers wrap 2→0 without loss.
- **Almost-full:** `DEPTH`=4, `ALMOST_FULL_TH`=3 → `almost_full_o` rises at `usage_o`=3, stays 1 at 4, falls on the pop back to 2.
- **Flush:** hold `count`=2, assert `flush_i` with simultaneous push 0x55 and pop → next cycle `usage_o`=0, `valid_o`=0, 0x55 never appears.
- **Fall-through** (macro defined): empty buffer, `valid_i`=1, `data_i`=0x77, `ready_i`=1 → `valid_o`=1, `data_o`=0x77 same cycle, `usage_o` stays 0. With macro undefined → 0x77 appears one cycle later.

Source files
------------

// File: rtl/axi_chan_buffer.sv
// axi_chan_buffer: parametrised ready/valid buffer for one AXI channel, with flush, fill level and almost-full.
// Define AXI_CHAN_BUFFER_FALL_THROUGH_EN to let a beat bypass storage combinationally when the buffer is empty.
module axi_chan_buffer #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned ALMOST_FULL_TH = DEPTH - 1,
  localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  testmode_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  almost_full_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_TH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign empty         = (count == '0);
  assign ready_o       = (count != FULL_CNT);
  assign usage_o       = count;
  assign almost_full_o = (count >= AF_CNT);
  assign pop           = ~empty & ready_i;

`ifdef AXI_CHAN_BUFFER_FALL_THROUGH_EN
  // An empty buffer forwards the incoming beat; it is only stored if downstream stalls it.
  logic bypass;
  assign bypass  = empty & valid_i & ready_i;
  assign valid_o = ~empty | (valid_i & ~flush_i);
  assign data_o  = empty ? data_i : mem[rd_ptr];
  assign push    = valid_i & ready_o & ~bypass;
`else
  assign valid_o = ~empty;
  assign data_o  = mem[rd_ptr];
  assign push    = valid_i & ready_o;
`endif

  // Flush resets the bookkeeping only and drops any handshake of that cycle; storage keeps its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
